// File: rtl/pipe_hazard_ctl_pkg.sv
// Shared pipeline definitions: operand-select encodings used by the hazard
// unit and the ID-stage operand muxes, plus the shadow-stage record.
package pipe_hazard_ctl_pkg;

   localparam logic [1:0] FWD_REG  = 2'b00;
   localparam logic [1:0] FWD_EALU = 2'b01;
   localparam logic [1:0] FWD_MALU = 2'b10;
   localparam logic [1:0] FWD_MMEM = 2'b11;

   localparam logic [15:0] STALLCNT_MAX = 16'hFFFF;

   typedef struct packed {
      logic       wreg;
      logic       m2reg;
      logic [4:0] rn;
   } shadow_t;

   localparam shadow_t SHADOW_BUBBLE = '{wreg: 1'b0, m2reg: 1'b0, rn: 5'd0};

   // True when stage s writes a non-zero register that the D operand r reads.
   function automatic logic src_hit(input shadow_t s, input logic uses, input logic [4:0] r);
      return uses && s.wreg && (s.rn != 5'd0) && (s.rn == r);
   endfunction

endpackage

// File: rtl/pipe_hazard_ctl_if.sv
// D-stage hazard bus between the decode stage (master) and the hazard
// controller (slave).
interface pipe_hazard_ctl_if;

   logic [4:0]  drs;
   logic [4:0]  drt;
   logic        dusers;
   logic        dusert;
   logic        dwreg;
   logic        dm2reg;
   logic [4:0]  drn;
   logic        flush;
   logic [1:0]  fwda;
   logic [1:0]  fwdb;
   logic        stall;
   logic [15:0] stallcnt;

   modport master (
      output drs, drt, dusers, dusert, dwreg, dm2reg, drn, flush,
      input  fwda, fwdb, stall, stallcnt
   );

   modport slave (
      input  drs, drt, dusers, dusert, dwreg, dm2reg, drn, flush,
      output fwda, fwdb, stall, stallcnt
   );

endinterface

// File: rtl/hz_shadow_stage.sv
// One shadow pipeline stage holding the destination info (wreg, m2reg, rn)
// of the instruction in that stage; a bubble loads all zeros.
module hz_shadow_stage
   import pipe_hazard_ctl_pkg::*;
(
   input  logic    clock,
   input  logic    reset,
   input  logic    bubble,
   input  shadow_t d_in,
   output shadow_t q_out
);

   shadow_t info_d;
   shadow_t info_q;

   // Select next stage contents: incoming instruction or a bubble.
   always_comb begin
      info_d = SHADOW_BUBBLE;
      if (bubble) begin
         info_d = SHADOW_BUBBLE;
      end else begin
         info_d = d_in;
      end
   end

   // Stage register with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         info_q <= SHADOW_BUBBLE;
      end else begin
         info_q <= info_d;
      end
   end

   assign q_out = info_q;

endmodule

// File: rtl/pipe_hazard_ctl.sv
// Hazard controller: forwarding selects and load-use stall for the D stage,
// computed combinationally from E/M shadow stages, plus a saturating stall
// counter.
module pipe_hazard_ctl
   import pipe_hazard_ctl_pkg::*;
(
   input logic               clock,
   input logic               reset,
   pipe_hazard_ctl_if.slave  hz
);

   shadow_t d_info_s;
   shadow_t e_info_s;
   shadow_t m_info_s;
   logic    e_bubble_s;
   logic    load_use_s;
   logic    stall_s;
   logic [1:0]  fwda_s;
   logic [1:0]  fwdb_s;
   logic [15:0] stallcnt_d;
   logic [15:0] stallcnt_q;

   assign d_info_s = '{wreg: hz.dwreg, m2reg: hz.dm2reg, rn: hz.drn};

   // A stalled or flushed D instruction must not enter E.
   assign e_bubble_s = stall_s | hz.flush;

   hz_shadow_stage u_e_stage (
      .clock  (clock),
      .reset  (reset),
      .bubble (e_bubble_s),
      .d_in   (d_info_s),
      .q_out  (e_info_s)
   );

   hz_shadow_stage u_m_stage (
      .clock  (clock),
      .reset  (reset),
      .bubble (1'b0),
      .d_in   (e_info_s),
      .q_out  (m_info_s)
   );

   // Load-use detection; a flushed D instruction never stalls.
   always_comb begin
      load_use_s = e_info_s.m2reg &&
                   (src_hit(e_info_s, hz.dusers, hz.drs) ||
                    src_hit(e_info_s, hz.dusert, hz.drt));
      stall_s = 1'b0;
      if (hz.flush) begin
         stall_s = 1'b0;
      end else begin
         stall_s = load_use_s;
      end
   end

   // Operand A select: E ALU result beats M, M ALU beats M memory data.
   always_comb begin
      fwda_s = FWD_REG;
      if (src_hit(e_info_s, hz.dusers, hz.drs) && !e_info_s.m2reg) begin
         fwda_s = FWD_EALU;
      end else if (src_hit(m_info_s, hz.dusers, hz.drs) && !m_info_s.m2reg) begin
         fwda_s = FWD_MALU;
      end else if (src_hit(m_info_s, hz.dusers, hz.drs)) begin
         fwda_s = FWD_MMEM;
      end else begin
         fwda_s = FWD_REG;
      end
   end

   // Operand B select, same priority as operand A.
   always_comb begin
      fwdb_s = FWD_REG;
      if (src_hit(e_info_s, hz.dusert, hz.drt) && !e_info_s.m2reg) begin
         fwdb_s = FWD_EALU;
      end else if (src_hit(m_info_s, hz.dusert, hz.drt) && !m_info_s.m2reg) begin
         fwdb_s = FWD_MALU;
      end else if (src_hit(m_info_s, hz.dusert, hz.drt)) begin
         fwdb_s = FWD_MMEM;
      end else begin
         fwdb_s = FWD_REG;
      end
   end

   // Next stall count, saturating at all-ones.
   always_comb begin
      stallcnt_d = stallcnt_q;
      if (stall_s && (stallcnt_q != STALLCNT_MAX)) begin
         stallcnt_d = stallcnt_q + 16'd1;
      end else begin
         stallcnt_d = stallcnt_q;
      end
   end

   // Stall counter register; reset overrides any pending stall.
   always_ff @(posedge clock) begin
      if (reset) begin
         stallcnt_q <= 16'd0;
      end else begin
         stallcnt_q <= stallcnt_d;
      end
   end

   assign hz.fwda     = fwda_s;
   assign hz.fwdb     = fwdb_s;
   assign hz.stall    = stall_s;
   assign hz.stallcnt = stallcnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Directed bench for pipe_hazard_ctl. Inputs change on the falling edge,
// outputs are checked 1 time unit later, far from the rising edge.
module tb_pipe_hazard_ctl;

   logic clock;
   logic reset;
   int   total;
   int   bad;

   pipe_hazard_ctl_if hz_if();

   pipe_hazard_ctl dut (
      .clock (clock),
      .reset (reset),
      .hz    (hz_if)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_d(input logic [4:0] rs, input logic [4:0] rt,
                        input logic us, input logic ut,
                        input logic wreg, input logic m2reg,
                        input logic [4:0] rn, input logic fl);
      hz_if.drs    = rs;
      hz_if.drt    = rt;
      hz_if.dusers = us;
      hz_if.dusert = ut;
      hz_if.dwreg  = wreg;
      hz_if.dm2reg = m2reg;
      hz_if.drn    = rn;
      hz_if.flush  = fl;
   endtask

   // Advance to the next falling edge.
   task automatic nxt();
      @(negedge clock);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      set_d(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      nxt(); nxt();
      reset = 1'b0;
      #1;
      chk("rst_fwda", {14'd0, hz_if.fwda}, 16'h0000);
      chk("rst_fwdb", {14'd0, hz_if.fwdb}, 16'h0000);
      chk("rst_stall", {15'd0, hz_if.stall}, 16'h0000);
      chk("rst_cnt", hz_if.stallcnt, 16'h0000);

      // add r3 enters E, then D reads rs=3
      set_d(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 1'b0);
      nxt();
      set_d(5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      #1;
      chk("e_alu_fwda", {14'd0, hz_if.fwda}, 16'h0001);
      chk("e_alu_fwdb", {14'd0, hz_if.fwdb}, 16'h0000);
      chk("e_alu_stall", {15'd0, hz_if.stall}, 16'h0000);
      // add r3 now in M; both operands read r3
      nxt();
      set_d(5'd3, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
      #1;
      chk("m_alu_fwda", {14'd0, hz_if.fwda}, 16'h0002);
      chk("m_alu_fwdb", {14'd0, hz_if.fwdb}, 16'h0002);

      // lw r5 in E, D reads rt=5 -> one stall, then select M memory
      nxt();
      set_d(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0);
      nxt();
      set_d(5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 5'd6, 1'b0);
      #1;
      chk("lu_stall", {15'd0, hz_if.stall}, 16'h0001);
      chk("lu_fwdb_e", {14'd0, hz_if.fwdb}, 16'h0000);
      chk("lu_cnt0", hz_if.stallcnt, 16'h0000);
      nxt();
      #1;
      chk("lu_stall_after", {15'd0, hz_if.stall}, 16'h0000);
      chk("lu_fwdb_mmem", {14'd0, hz_if.fwdb}, 16'h0003);
      chk("lu_fwda_after", {14'd0, hz_if.fwda}, 16'h0000);
      chk("lu_cnt1", hz_if.stallcnt, 16'h0001);

      // r7: load in M, ALU op in E -> E wins
      nxt();
      set_d(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0);
      nxt();
      set_d(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd7, 1'b0);
      nxt();
      set_d(5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
      #1;
      chk("prio_fwda", {14'd0, hz_if.fwda}, 16'h0001);
      chk("prio_fwdb", {14'd0, hz_if.fwdb}, 16'h0001);
      chk("prio_stall", {15'd0, hz_if.stall}, 16'h0000);

      // r0 writers in E and M: never forward or stall
      nxt();
      set_d(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0);
      nxt();
      set_d(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
      #1;
      chk("r0_load_stall", {15'd0, hz_if.stall}, 16'h0000);
      nxt();
      set_d(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
      #1;
      chk("r0_fwda", {14'd0, hz_if.fwda}, 16'h0000);
      chk("r0_fwdb", {14'd0, hz_if.fwdb}, 16'h0000);
      chk("r0_stall", {15'd0, hz_if.stall}, 16'h0000);

      // different sources in one cycle: rs from E ALU, rt from M memory
      nxt();
      set_d(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0);
      nxt();
      set_d(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd10, 1'b0);
      nxt();
      set_d(5'd10, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
      #1;
      chk("mix_fwda", {14'd0, hz_if.fwda}, 16'h0001);
      chk("mix_fwdb", {14'd0, hz_if.fwdb}, 16'h0003);

      // load-use with flush: no stall, E zeroed, counter unchanged
      nxt();
      set_d(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0);
      nxt();
      set_d(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd8, 1'b1);
      #1;
      chk("flush_stall", {15'd0, hz_if.stall}, 16'h0000);
      chk("flush_cnt", hz_if.stallcnt, 16'h0001);
      nxt();
      set_d(5'd8, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
      #1;
      chk("flush_e_zero", {14'd0, hz_if.fwda}, 16'h0000);
      chk("flush_m_load", {14'd0, hz_if.fwdb}, 16'h0003);
      chk("flush_cnt_hold", hz_if.stallcnt, 16'h0001);

      // reset during a stall drops it and clears the counter
      nxt();
      set_d(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0);
      nxt();
      set_d(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
      reset = 1'b1;
      #1;
      chk("mid_stall_pre", {15'd0, hz_if.stall}, 16'h0001);
      nxt();
      #1;
      chk("mid_stall_drop", {15'd0, hz_if.stall}, 16'h0000);
      chk("mid_stall_cnt", hz_if.stallcnt, 16'h0000);

      // saturation: self-dependent load stalls every other cycle
      reset = 1'b0;
      set_d(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0);
      repeat (2 * 65534) @(negedge clock);
      #1;
      chk("sat_cnt_fffe", hz_if.stallcnt, 16'hFFFE);
      chk("sat_even_stall", {15'd0, hz_if.stall}, 16'h0000);
      nxt();
      #1;
      chk("sat_odd_stall", {15'd0, hz_if.stall}, 16'h0001);
      nxt();
      #1;
      chk("sat_cnt_ffff", hz_if.stallcnt, 16'hFFFF);
      nxt();
      #1;
      chk("sat_stall_again", {15'd0, hz_if.stall}, 16'h0001);
      nxt();
      #1;
      chk("sat_hold", hz_if.stallcnt, 16'hFFFF);
      nxt();
      reset = 1'b1;
      nxt();
      #1;
      chk("final_rst_cnt", hz_if.stallcnt, 16'h0000);
      chk("final_rst_stall", {15'd0, hz_if.stall}, 16'h0000);
      chk("final_rst_fwda", {14'd0, hz_if.fwda}, 16'h0000);
      chk("final_rst_fwdb", {14'd0, hz_if.fwdb}, 16'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
